// File: rtl/beam_scan_controller.sv
// Closed-loop beam steering: sweeps all 32 delay settings, measures mean |sum|
// per direction, steers to the loudest one, holds, then re-scans.
module beam_scan_controller #(
    parameter int unsigned SETTLE_FRAMES = 4,
    parameter int unsigned LOG_FRAMES    = 6,
    parameter int unsigned HOLD_FRAMES   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lr_clk,
    input  logic                     enable,
    input  logic signed [21:0]       sample_in,
    output logic [4:0]               delay_select,
    output logic [4:0]               best_dir,
    output logic                     best_valid,
    output logic                     scanning,
    output logic [22+LOG_FRAMES-1:0] peak_energy
);
    localparam int unsigned ACCW       = 22 + LOG_FRAMES;
    localparam int unsigned ACC_FRAMES = 1 << LOG_FRAMES;
    localparam int unsigned MAX_SA     = (SETTLE_FRAMES > ACC_FRAMES) ? SETTLE_FRAMES : ACC_FRAMES;
    localparam int unsigned MAXC       = (MAX_SA > HOLD_FRAMES) ? MAX_SA : HOLD_FRAMES;
    localparam int unsigned CW         = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_FRAMES - 1);
    localparam logic [CW-1:0] ACC_LAST    = CW'(ACC_FRAMES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, HOLD} state_t;

    state_t            state_q, state_d;
    logic              lr_q;
    logic [4:0]        idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [ACCW-1:0]   run_max_q, run_max_d;
    logic [4:0]        run_idx_q, run_idx_d;
    logic [4:0]        best_dir_q, best_dir_d;
    logic [ACCW-1:0]   peak_q, peak_d;
    logic              best_valid_q, best_valid_d;
    logic [4:0]        dsel_q, dsel_d;
    logic              scanning_q, scanning_d;

    logic              strobe;
    logic [21:0]       mag;
    logic [ACCW-1:0]   sum;
    logic              win;
    logic [ACCW-1:0]   new_max;
    logic [4:0]        new_idx;

    assign strobe  = lr_clk & ~lr_q;
    // Two's-complement negate of -2^21 wraps to bit pattern 2^21, which is the right magnitude.
    assign mag     = sample_in[21] ? unsigned'(-sample_in) : unsigned'(sample_in);
    assign sum     = acc_q + ACCW'(mag);
    assign win     = sum > run_max_q;
    assign new_max = win ? sum : run_max_q;
    assign new_idx = win ? idx_q : run_idx_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        run_max_d    = run_max_q;
        run_idx_d    = run_idx_q;
        best_dir_d   = best_dir_q;
        peak_d       = peak_q;
        best_valid_d = best_valid_q;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SETTLE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    run_max_d = '0;
                    run_idx_d = '0;
                end
                SETTLE: if (strobe) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ACCUM;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ACCUM: if (strobe) begin
                    if (cnt_q == ACC_LAST) begin
                        run_max_d = new_max;
                        run_idx_d = new_idx;
                        cnt_d     = '0;
                        if (idx_q != 5'd31) begin
                            idx_d   = idx_q + 5'd1;
                            state_d = SETTLE;
                        end else begin
                            state_d      = HOLD;
                            best_dir_d   = new_idx;
                            peak_d       = new_max;
                            best_valid_d = 1'b1;
                        end
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLD: if (strobe) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d   = SETTLE;
                        idx_d     = '0;
                        cnt_d     = '0;
                        run_max_d = '0;
                        run_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are derived from the next state so they register in step with it.
        dsel_d     = '0;
        scanning_d = 1'b0;
        case (state_d)
            IDLE:          dsel_d = best_valid_d ? best_dir_d : 5'd0;
            SETTLE, ACCUM: begin
                dsel_d     = idx_d;
                scanning_d = 1'b1;
            end
            HOLD:          dsel_d = best_dir_d;
            default:       dsel_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lr_q         <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            run_max_q    <= '0;
            run_idx_q    <= '0;
            best_dir_q   <= '0;
            peak_q       <= '0;
            best_valid_q <= 1'b0;
            dsel_q       <= '0;
            scanning_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lr_q         <= lr_clk;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            run_max_q    <= run_max_d;
            run_idx_q    <= run_idx_d;
            best_dir_q   <= best_dir_d;
            peak_q       <= peak_d;
            best_valid_q <= best_valid_d;
            dsel_q       <= dsel_d;
            scanning_q   <= scanning_d;
        end
    end

    assign delay_select = dsel_q;
    assign best_dir     = best_dir_q;
    assign best_valid   = best_valid_q;
    assign scanning     = scanning_q;
    assign peak_energy  = peak_q;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Directed bench for beam_scan_controller: frame-level stimulus with hand-computed results.
module tb_beam_scan_controller;
    localparam int SF = 4;
    localparam int LF = 6;
    localparam int NF = 64;
    localparam int HF = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              lr_clk;
    logic              enable;
    logic signed [21:0] sample_in;
    logic [4:0]        delay_select;
    logic [4:0]        best_dir;
    logic              best_valid;
    logic              scanning;
    logic [27:0]       peak_energy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    beam_scan_controller #(
        .SETTLE_FRAMES(SF),
        .LOG_FRAMES   (LF),
        .HOLD_FRAMES  (HF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lr_clk      (lr_clk),
        .enable      (enable),
        .sample_in   (sample_in),
        .delay_select(delay_select),
        .best_dir    (best_dir),
        .best_valid  (best_valid),
        .scanning    (scanning),
        .peak_energy (peak_energy)
    );

    // One lr_clk frame: rising edge gives one strobe; entered and left on a negedge.
    task automatic frame(input logic signed [21:0] v);
        sample_in = v;
        lr_clk    = 1'b1;
        repeat (2) @(negedge clk);
        lr_clk    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sweep(input int n_idx, input int pa, input int va, input int pb,
                         input int vb, input int vset, input int vbase);
        for (int i = 0; i < n_idx; i++) begin
            n_vec++;
            if (delay_select !== 5'(i) || scanning !== 1'b1) begin
                n_err++;
                $display("FAIL sweep_dsel idx %0d: delay_select=%0d scanning=%0b, expected %0d/1",
                         i, delay_select, scanning, i);
            end
            repeat (SF) frame(22'(vset));
            for (int f = 0; f < NF; f++)
                frame((i == pa) ? 22'(va) : (i == pb) ? 22'(vb) : 22'(vbase));
        end
    endtask

    task automatic begin_sweep();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({delay_select, best_dir, best_valid, scanning, peak_energy} !== '0) begin
            n_err++;
            $display("FAIL reset_vals: dsel=%0d best=%0d valid=%0b scan=%0b peak=%0d, expected all 0",
                     delay_select, best_dir, best_valid, scanning, peak_energy);
        end
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        n_vec++;
        if (scanning !== 1'b1 || delay_select !== 5'd0) begin
            n_err++;
            $display("FAIL enable_start: scanning=%0b dsel=%0d, expected 1/0", scanning, delay_select);
        end
        repeat (SF) frame(22'sd50);
        repeat (3) frame(22'sd50);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({delay_select, best_dir, best_valid, scanning, peak_energy} !== '0) begin
            n_err++;
            $display("FAIL reset_accum: dsel=%0d best=%0d valid=%0b scan=%0b peak=%0d, expected all 0",
                     delay_select, best_dir, best_valid, scanning, peak_energy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (scanning !== 1'b1 || delay_select !== 5'd0) begin
            n_err++;
            $display("FAIL restart_after_reset: scanning=%0b dsel=%0d, expected 1/0", scanning, delay_select);
        end
    endtask

    task automatic test_single_peak();
        sweep(32, 13, 1000, -1, 0, 10, 10);
        n_vec++;
        if ({best_dir, peak_energy, best_valid, scanning, delay_select} !==
            {5'd13, 28'd64000, 1'b1, 1'b0, 5'd13}) begin
            n_err++;
            $display("FAIL single_peak: best=%0d peak=%0d valid=%0b scan=%0b dsel=%0d, expected 13/64000/1/0/13",
                     best_dir, peak_energy, best_valid, scanning, delay_select);
        end
    endtask

    task automatic test_enable_drop();
        repeat (HF) frame(22'sd0);
        sweep(17, 13, 1000, -1, 0, 10, 10);
        repeat (SF) frame(22'sd10);
        repeat (10) frame(22'sd10);
        n_vec++;
        if (delay_select !== 5'd17) begin
            n_err++;
            $display("FAIL drop_pre: dsel=%0d, expected 17", delay_select);
        end
        enable = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({delay_select, scanning, best_valid, best_dir, peak_energy} !==
            {5'd13, 1'b0, 1'b1, 5'd13, 28'd64000}) begin
            n_err++;
            $display("FAIL drop_idle: dsel=%0d scan=%0b valid=%0b best=%0d peak=%0d, expected 13/0/1/13/64000",
                     delay_select, scanning, best_valid, best_dir, peak_energy);
        end
        frame(22'sd10);
        n_vec++;
        if (delay_select !== 5'd13 || scanning !== 1'b0) begin
            n_err++;
            $display("FAIL drop_strobe_ignored: dsel=%0d scan=%0b, expected 13/0", delay_select, scanning);
        end
        enable = 1'b1;
        @(negedge clk);
        n_vec++;
        if (scanning !== 1'b1 || delay_select !== 5'd0) begin
            n_err++;
            $display("FAIL reenable: scanning=%0b dsel=%0d, expected 1/0", scanning, delay_select);
        end
        sweep(32, 13, 2000, -1, 0, 0, 0);
        n_vec++;
        if ({best_dir, peak_energy, best_valid, delay_select} !== {5'd13, 28'd128000, 1'b1, 5'd13}) begin
            n_err++;
            $display("FAIL reenable_sweep: best=%0d peak=%0d valid=%0b dsel=%0d, expected 13/128000/1/13",
                     best_dir, peak_energy, best_valid, delay_select);
        end
    endtask

    task automatic test_hold_rescan();
        for (int h = 0; h < HF; h++) begin
            n_vec++;
            if (delay_select !== 5'd13 || scanning !== 1'b0) begin
                n_err++;
                $display("FAIL hold_frame %0d: dsel=%0d scan=%0b, expected 13/0", h, delay_select, scanning);
            end
            frame(22'sd0);
        end
        sweep(32, 2, 1000, -1, 0, 0, 0);
        n_vec++;
        if ({best_dir, peak_energy, best_valid, delay_select} !== {5'd2, 28'd64000, 1'b1, 5'd2}) begin
            n_err++;
            $display("FAIL rescan: best=%0d peak=%0d valid=%0b dsel=%0d, expected 2/64000/1/2",
                     best_dir, peak_energy, best_valid, delay_select);
        end
    endtask

    task automatic test_neg_fullscale();
        begin_sweep();
        sweep(32, 31, -2097152, -1, 0, 0, 0);
        n_vec++;
        if ({best_dir, peak_energy, best_valid, delay_select} !== {5'd31, 28'd134217728, 1'b1, 5'd31}) begin
            n_err++;
            $display("FAIL neg_fullscale: best=%0d peak=%0d valid=%0b dsel=%0d, expected 31/134217728/1/31",
                     best_dir, peak_energy, best_valid, delay_select);
        end
    endtask

    task automatic test_tie();
        begin_sweep();
        sweep(32, 5, 500, 20, 500, 9999, 0);
        n_vec++;
        if ({best_dir, peak_energy, best_valid, delay_select} !== {5'd5, 28'd32000, 1'b1, 5'd5}) begin
            n_err++;
            $display("FAIL tie: best=%0d peak=%0d valid=%0b dsel=%0d, expected 5/32000/1/5",
                     best_dir, peak_energy, best_valid, delay_select);
        end
    endtask

    task automatic test_reset_mid();
        repeat (HF) frame(22'sd0);
        repeat (SF) frame(22'sd100);
        repeat (3) frame(22'sd100);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({delay_select, best_dir, best_valid, scanning, peak_energy} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: dsel=%0d best=%0d valid=%0b scan=%0b peak=%0d, expected all 0",
                     delay_select, best_dir, best_valid, scanning, peak_energy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (scanning !== 1'b1 || delay_select !== 5'd0 || best_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_restart: scan=%0b dsel=%0d valid=%0b, expected 1/0/0",
                     scanning, delay_select, best_valid);
        end
        enable = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        lr_clk    = 1'b0;
        enable    = 1'b0;
        sample_in = '0;
        test_reset();
        test_single_peak();
        test_enable_drop();
        test_hold_rescan();
        test_neg_fullscale();
        test_tie();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
